note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//  Records keyboard notes as (ascii, duration) entries in an internal buffer and replays them to the tone rate divider.
//  Arbitrates the single tone path: live key passthrough when idle/recording, recorded stream during playback.
//  Sits between the PS/2 ascii decoder and the rate divider / loaded-playback rate divider inputs.
// PARAMETERS
//  CLK_HZ   50000000  system clock frequency
//  TICK_HZ  1000      duration time base (1 ms per tick)
//  DEPTH    64        note buffer entries (power of 2)
//  DUR_W    16        duration field width in ticks
// PORTS
//  clk          in   1      system clock
//  resetn       in   1      synchronous active-low reset
//  key_ascii    in   7      ascii of held key from the keyboard decoder
//  key_valid    in   1      1 = a key is currently held
//  rec_start    in   1      one-cycle pulse: begin recording (clears buffer)
//  rec_stop     in   1      one-cycle pulse: end recording
//  play_start   in   1      one-cycle pulse: begin playback from entry 0
//  play_stop    in   1      one-cycle pulse: abort playback
//  ascii_out    out  7      note code to rate divider (7'd0 = rest)
//  tone_en      out  1      speaker gate (drives is_loading of the load divider)
//  busy_rec     out  1      1 while in RECORD
//  busy_play    out  1      1 while in PLAY_FETCH/PLAY_NOTE
//  note_count   out  $clog2(DEPTH)+1  entries stored
//  overflow     out  1      sticky: recording hit DEPTH; cleared by rec_start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, buffer contents don't-care, tick prescaler 0.
//  Tick: prescaler counts 0..CLK_HZ/TICK_HZ-1, one-cycle tick on wrap; restarts at 0 on entering RECORD or PLAY_NOTE.
//  States: IDLE, RECORD, PLAY_FETCH, PLAY_NOTE.
//  IDLE: ascii_out = key_valid ? key_ascii : 0; tone_en = key_valid (registered, 1-cycle latency).
//   rec_start -> RECORD (note_count:=0, overflow:=0, cur:=live note, dur:=0). play_start -> PLAY_FETCH, rd_ptr:=0.
//   Simultaneous rec_start & play_start: rec_start wins. Start pulses in non-IDLE states ignored.
//  RECORD: live passthrough as IDLE. dur increments per tick, saturating at 2^DUR_W-1.
//   On live note != cur, or dur saturated on a tick: if dur>0 write {cur,dur}, note_count++; cur:=live note, dur:=0.
//   Rests (key_valid=0) are stored as ascii 0. rec_stop: flush {cur,dur} if dur>0, -> IDLE.
//   Write when note_count==DEPTH: drop it, overflow:=1, -> IDLE.
//  PLAY_FETCH: buffer read, 1-cycle latency; if rd_ptr==note_count -> IDLE (empty buffer: IDLE after 1 cycle).
//   else load {note,dur} into output regs -> PLAY_NOTE.
//  PLAY_NOTE: ascii_out = note; tone_en = (note!=0). Count dur ticks; on last tick rd_ptr++ -> PLAY_FETCH.
//  play_stop (any play state) or rec_stop ignored in play: play_stop -> IDLE next cycle, tone_en:=0.
//  Duration accuracy: each note plays dur ticks + 1-2 clk fetch gap.
// CONFIGURATION
//  LOOP_PLAYBACK_EN defined: at rd_ptr==note_count (note_count>0) wrap rd_ptr:=0, continue until play_stop.
//  Not defined: playback ends in IDLE after the last entry.
// STRUCTURE
//  beat_pkg: state enum, ASCII_REST=7'd0, entry struct {ascii[6:0], dur[DUR_W-1:0]}.
//  Sub-module note_ram: single-port sync-read RAM, DEPTH x (7+DUR_W), inferred block RAM.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> 10 clk/tick, DEPTH=4)
//  Reset mid-PLAY_NOTE -> next cycle ascii_out=0, tone_en=0, busy_play=0, note_count=0.
//  rec_start; hold 'A'(65) 30 clk, release 20 clk, hold 'D'(68) 40 clk; rec_stop -> note_count=3 {65,3},{0,2},{68,4}.
//  Then play_start -> ascii_out 65 for 3 ticks, tone_en=0 for 2 ticks, 68 for 4 ticks, then IDLE, busy_play=0.
//  Record 5 distinct notes -> 4 stored, overflow=1, IDLE; next rec_start clears overflow.
//  rec_start & play_start same cycle in IDLE -> busy_rec=1, busy_play=0; play_start with note_count=0 -> IDLE after 2 clk.
//  LOOP_PLAYBACK_EN: 2-entry buffer replays 65,68,65,... until play_stop; play_stop -> tone_en=0 next cycle.

Source files
------------

// File: rtl/beat_pkg.sv
// Shared types for the note sequencer: FSM state encoding and the rest code.
package beat_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECORD,
        ST_PLAY_FETCH,
        ST_PLAY_NOTE
    } state_t;

    localparam logic [6:0] ASCII_REST = 7'd0;

    // A released keyboard is recorded and played as the rest code.
    function automatic logic [6:0] live_note(input logic valid, input logic [6:0] ascii);
        return valid ? ascii : ASCII_REST;
    endfunction

endpackage

// File: rtl/note_ram.sv
// Single-port note buffer with registered read (read-before-write), maps onto block RAM.
module note_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    // NOTE: the array has no reset so synthesis can map it to block RAM; contents start undefined.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Records live key notes as (ascii, duration) entries and replays them onto the tone path.
// Define LOOP_PLAYBACK_EN to make playback wrap to entry 0 until play_stop.
module note_sequencer
    import beat_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1000,
    parameter int DEPTH   = 64,
    parameter int DUR_W   = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [6:0]                 key_ascii,
    input  logic                       key_valid,
    input  logic                       rec_start,
    input  logic                       rec_stop,
    input  logic                       play_start,
    input  logic                       play_stop,
    output logic [6:0]                 ascii_out,
    output logic                       tone_en,
    output logic                       busy_rec,
    output logic                       busy_play,
    output logic [$clog2(DEPTH):0]     note_count,
    output logic                       overflow
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int EW  = 7 + DUR_W;
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    typedef struct packed {
        logic [6:0]       ascii;
        logic [DUR_W-1:0] dur;
    } entry_t;

    state_t           state, state_d;
    logic [PW-1:0]    presc, presc_d;
    logic [6:0]       cur, cur_d;
    logic [DUR_W-1:0] dur, dur_d;
    logic [DUR_W-1:0] pdur, pdur_d;
    logic [CW-1:0]    cnt_d;
    logic [CW-1:0]    rd_ptr, rd_d;
    logic             ovf_d;
    logic [6:0]       ascii_d;
    logic             tone_d;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [EW-1:0]    ram_rdata;
    entry_t           rd_entry;
    logic             tick;
    logic [6:0]       live;
    logic             flush;

    assign tick      = (presc == PW'(DIV - 1));
    assign live      = live_note(key_valid, key_ascii);
    assign rd_entry  = ram_rdata;
    assign busy_rec  = (state == ST_RECORD);
    assign busy_play = (state == ST_PLAY_FETCH) || (state == ST_PLAY_NOTE);
    // Reads are addressed by the next pointer so PLAY_FETCH sees its entry one cycle later.
    assign ram_addr  = ram_we ? note_count[AW-1:0] : rd_d[AW-1:0];

    note_ram #(.DEPTH(DEPTH), .WIDTH(EW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata ({cur, dur}),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
        if (!resetn) begin
            state      <= ST_IDLE;
            presc      <= '0;
            cur        <= ASCII_REST;
            dur        <= '0;
            pdur       <= '0;
            note_count <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            ascii_out  <= ASCII_REST;
            tone_en    <= 1'b0;
        end else begin
            state      <= state_d;
            presc      <= presc_d;
            cur        <= cur_d;
            dur        <= dur_d;
            pdur       <= pdur_d;
            note_count <= cnt_d;
            rd_ptr     <= rd_d;
            overflow   <= ovf_d;
            ascii_out  <= ascii_d;
            tone_en    <= tone_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state;
        presc_d = tick ? '0 : presc + PW'(1);
        cur_d   = cur;
        dur_d   = dur;
        pdur_d  = pdur;
        cnt_d   = note_count;
        rd_d    = rd_ptr;
        ovf_d   = overflow;
        ascii_d = ascii_out;
        tone_d  = tone_en;
        ram_we  = 1'b0;
        flush   = 1'b0;

        case (state)
            ST_IDLE: begin
                ascii_d = live;
                tone_d  = key_valid;
                if (rec_start) begin
                    state_d = ST_RECORD;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    cur_d   = live;
                    dur_d   = '0;
                    presc_d = '0;
                end else if (play_start) begin
                    state_d = ST_PLAY_FETCH;
                    rd_d    = '0;
                end
            end

            ST_RECORD: begin
                ascii_d = live;
                tone_d  = key_valid;
                flush   = rec_stop || (live != cur) || (tick && dur == DUR_MAX);
                if (flush) begin
                    if (dur != '0) begin
                        if (note_count == CW'(DEPTH)) begin
                            ovf_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ram_we = 1'b1;
                            cnt_d  = note_count + CW'(1);
                        end
                    end
                    cur_d = live;
                    dur_d = '0;
                    if (rec_stop)
                        state_d = ST_IDLE;
                end else if (tick) begin
                    dur_d = dur + DUR_W'(1);
                end
            end

            ST_PLAY_FETCH: begin
                if (rd_ptr == note_count) begin
`ifdef LOOP_PLAYBACK_EN
                    if (note_count != '0) begin
                        rd_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        ascii_d = ASCII_REST;
                        tone_d  = 1'b0;
                    end
`else
                    state_d = ST_IDLE;
                    ascii_d = ASCII_REST;
                    tone_d  = 1'b0;
`endif
                end else begin
                    ascii_d = rd_entry.ascii;
                    tone_d  = (rd_entry.ascii != ASCII_REST);
                    pdur_d  = rd_entry.dur;
                    dur_d   = '0;
                    presc_d = '0;
                    state_d = ST_PLAY_NOTE;
                end
            end

            ST_PLAY_NOTE: begin
                if (tick) begin
                    if (dur == pdur - DUR_W'(1)) begin
                        rd_d    = rd_ptr + CW'(1);
                        dur_d   = '0;
                        state_d = ST_PLAY_FETCH;
                    end else begin
                        dur_d = dur + DUR_W'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (busy_play && play_stop) begin
            state_d = ST_IDLE;
            ascii_d = ASCII_REST;
            tone_d  = 1'b0;
        end
    end

endmodule
